// File: rtl/stepmotor_seq_master.sv
// stepmotor_seq_master: Avalon-MM step sequencer writing coil phases to the stepper PIO.
// Define STEPMOTOR_HALFSTEP_EN to add the cmd_half port and the 8-entry half-step table.
module stepmotor_seq_master #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
`ifdef STEPMOTOR_HALFSTEP_EN
  input  logic                cmd_half,
`endif
  input  logic                abort,
  output logic [1:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_write_n,
  output logic [31:0]         avm_writedata,
  input  logic                avm_waitrequest,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   position
);
`ifdef STEPMOTOR_HALFSTEP_EN
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_RST = 3'd1;
  localparam logic [31:0] TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                   4'b0110, 4'b0100, 4'b1100, 4'b1000};
`else
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_RST = 2'd0;
  localparam logic [15:0] TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_FIN} state_t;
  state_t              r_state, w_next;
  logic                r_ready, r_busy, r_done, r_cs, r_wn, r_dir, r_abort_pend;
  logic [STEP_W-1:0]   r_rem, r_pos;
  logic [PERIOD_W-1:0] r_period, r_cnt, w_period;
  logic [IDX_W-1:0]    r_idx, w_idx_next, w_stride;
  logic [3:0]          w_phase;
  logic [31:0]         r_wd;
`ifdef STEPMOTOR_HALFSTEP_EN
  logic                r_half;
  // Full steps move by two so the index parity, and thus the pattern family, is preserved.
  assign w_stride = r_half ? 3'd1 : 3'd2;
`else
  assign w_stride = 2'd1;
`endif
  assign w_period   = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
  assign w_idx_next = r_dir ? r_idx + w_stride : r_idx - w_stride;
  assign w_phase    = TABLE[{w_idx_next, 2'b00} +: 4];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = (cmd_steps == '0) ? S_FIN : S_WAIT;
      S_WAIT:  w_next = abort ? S_FIN : (r_cnt == PERIOD_W'(1)) ? S_WRITE : S_WAIT;
      S_WRITE: if (!avm_waitrequest)
                 w_next = (r_rem == STEP_W'(1) || abort || r_abort_pend) ? S_FIN : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_wd         <= '0;
      r_dir        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_rem        <= '0;
      r_pos        <= '0;
      r_period     <= '0;
      r_cnt        <= '0;
      r_idx        <= IDX_RST;
`ifdef STEPMOTOR_HALFSTEP_EN
      r_half       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_ready <= w_next == S_IDLE;
      r_busy  <= w_next != S_IDLE;
      r_done  <= w_next == S_FIN;
      r_cs    <= w_next == S_WRITE;
      r_wn    <= w_next != S_WRITE;
      if (r_state == S_IDLE && cmd_valid) begin
        r_dir        <= cmd_dir;
        r_rem        <= cmd_steps;
        r_period     <= w_period;
        r_cnt        <= w_period;
        r_abort_pend <= 1'b0;
`ifdef STEPMOTOR_HALFSTEP_EN
        r_half       <= cmd_half;
`endif
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt - PERIOD_W'(1);
      if (r_state == S_WAIT && w_next == S_WRITE) begin
        r_idx <= w_idx_next;
        r_wd  <= {26'd0, r_dir, 1'b1, w_phase};
      end
      if (r_state == S_WRITE) begin
        if (abort) r_abort_pend <= 1'b1;
        if (!avm_waitrequest) begin
          r_pos <= r_pos + (r_dir ? STEP_W'(1) : {STEP_W{1'b1}});
          r_rem <= r_rem - STEP_W'(1);
          r_cnt <= r_period;
        end
      end
    end
  end
  assign cmd_ready      = r_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_writedata  = r_wd;
  assign avm_address    = 2'd0;
  assign position       = r_pos;
endmodule

// File: tb/tb_stepmotor_seq_master.sv
// tb_stepmotor_seq_master: table vectors, hand-built stall/abort/reset sequences and random moves vs a step model.
module tb_stepmotor_seq_master;
  logic        clk = 0, reset_n = 0, cmd_valid = 0, cmd_ready, cmd_dir = 0, abort = 0;
  logic [15:0] cmd_steps = 0, position;
  logic [23:0] cmd_period = 0;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n, avm_waitrequest = 0, busy, done;
  logic [31:0] avm_writedata;
  stepmotor_seq_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .position(position)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0, cyc = 0, acc_cyc = 0, cs_cnt = 0, cur_p = 1;
  logic cur_dir = 0;
  int wr_start[$], wr_end[$], done_q[$];
  logic [31:0] wr_data[$];
  logic prev_cs = 0, prev_stall = 0;
  logic [31:0] prev_data = 0;
  // Reference model: phase index into the full-step table and absolute position.
  logic [3:0] ft [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  int m_idx = 0;
  logic [15:0] m_pos = 0;
  typedef struct {
    logic        dir;
    logic [15:0] steps;
    logic [23:0] period;
    int          n;
    logic [31:0] first, last;
    logic [15:0] pos;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_cs = 0;
      prev_stall = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (avm_chipselect) cs_cnt++;
      if (avm_chipselect && !prev_cs) wr_start.push_back(cyc);
      if (prev_stall)
        chk("stall_hold", {avm_chipselect, avm_write_n, avm_writedata}, {1'b1, 1'b0, prev_data});
      chk("strobe", {avm_write_n, avm_address}, {!avm_chipselect, 2'b00});
      if (avm_chipselect && !avm_waitrequest) begin
        wr_end.push_back(cyc);
        wr_data.push_back(avm_writedata);
      end
      if (done) done_q.push_back(cyc);
      prev_cs = avm_chipselect;
      prev_stall = avm_chipselect && avm_waitrequest;
      prev_data = avm_writedata;
    end
  end
  task automatic start_cmd(input logic dir, input logic [15:0] steps, input logic [23:0] period);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(posedge clk) #1;
    if (!cmd_ready) begin
      vecs++; errs++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    wr_start.delete(); wr_end.delete(); wr_data.delete(); done_q.delete();
    cs_cnt = 0;
    cur_dir = dir;
    cur_p = (period == 0) ? 1 : int'(period);
    cmd_dir = dir; cmd_steps = steps; cmd_period = period; cmd_valid = 1;
    @(posedge clk) #1;
    cmd_valid = 0;
  endtask
  task automatic finish_cmd(input int n, input bit chk_t, input bit rnd);
    int exp_s;
    for (int i = 0; i < 3000 && done_q.size() == 0; i++) begin
      @(posedge clk) #1;
      if (rnd) avm_waitrequest = ($urandom_range(0, 2) == 0);
    end
    avm_waitrequest = 0;
    if (done_q.size() == 0) begin
      vecs++; errs++;
      $display("FAIL done_timeout: got no done expected a done pulse");
      return;
    end
    chk("idle_after_done", {cmd_ready, busy, done}, 3'b100);
    chk("nwrites", wr_end.size(), n);
    for (int k = 0; k < n; k++) begin
      m_idx = (m_idx + (cur_dir ? 1 : 3)) % 4;
      m_pos = m_pos + (cur_dir ? 16'd1 : 16'hFFFF);
      if (k < wr_data.size()) chk("wdata", wr_data[k], {26'd0, cur_dir, 1'b1, ft[m_idx]});
      if (k < wr_start.size()) begin
        exp_s = ((k == 0) ? acc_cyc : wr_end[k-1]) + cur_p + 1;
        chk("wstart", wr_start[k], exp_s);
      end
    end
    if (chk_t && (n == 0 || wr_end.size() == n))
      chk("done_cycle", done_q[0], (n == 0) ? acc_cyc + 1 : wr_end[n-1] + 1);
    chk("done_once", done_q.size(), 1);
    chk("position", position, m_pos);
  endtask
  initial begin
    tbl[0] = '{1'b1, 16'd3, 24'd4,   3, 32'h36, 32'h39, 16'd3};
    tbl[1] = '{1'b0, 16'd2, 24'd0,   2, 32'h13, 32'h16, 16'd1};
    tbl[2] = '{1'b1, 16'd0, 24'd100, 0, 32'h0,  32'h0,  16'd1};
    tbl[3] = '{1'b0, 16'd3, 24'd1,   3, 32'h1C, 32'h13, 16'hFFFE};
    tbl[4] = '{1'b1, 16'd4, 24'd2,   4, 32'h39, 32'h33, 16'd2};
    repeat (3) @(posedge clk);
    #3;
    chk("reset_vals", {avm_chipselect, avm_write_n, avm_address, avm_writedata, done, busy, position, cmd_ready},
        {1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1});
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      start_cmd(tbl[i].dir, tbl[i].steps, tbl[i].period);
      finish_cmd(tbl[i].n, 1, 0);
      if (tbl[i].n > 0 && wr_data.size() == tbl[i].n) begin
        chk("tbl_first", wr_data[0], tbl[i].first);
        chk("tbl_last", wr_data[tbl[i].n-1], tbl[i].last);
      end
      if (tbl[i].n == 0) chk("tbl_no_cs", cs_cnt, 0);
      chk("tbl_pos", position, tbl[i].pos);
    end
    // Three stalled cycles on the first write hold the strobe for four cycles.
    avm_waitrequest = 1;
    start_cmd(1, 16'd1, 24'd2);
    for (int i = 0; i < 100 && !avm_chipselect; i++) @(posedge clk) #1;
    repeat (3) @(posedge clk) #1;
    avm_waitrequest = 0;
    finish_cmd(1, 1, 0);
    chk("stall_cs_cycles", cs_cnt, 4);
    if (wr_end.size() == 1 && wr_start.size() == 1) chk("stall_len", wr_end[0] - wr_start[0], 3);
    // Abort while waiting for the second step.
    start_cmd(1, 16'd5, 24'd10);
    for (int i = 0; i < 100 && wr_end.size() == 0; i++) @(posedge clk) #1;
    repeat (3) @(posedge clk) #1;
    abort = 1;
    @(posedge clk) #1;
    abort = 0;
    finish_cmd(1, 0, 0);
    // Abort during a stalled write: that transfer still completes and counts.
    avm_waitrequest = 1;
    start_cmd(1, 16'd5, 24'd10);
    for (int i = 0; i < 100 && !avm_chipselect; i++) @(posedge clk) #1;
    abort = 1;
    @(posedge clk) #1;
    abort = 0;
    @(posedge clk) #1;
    avm_waitrequest = 0;
    finish_cmd(1, 1, 0);
    for (int r = 0; r < 14; r++) begin
      start_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)), 24'($urandom_range(0, 5)));
      finish_cmd(int'(cmd_steps), 1, 1);
    end
    // Reset while a write is stalled.
    avm_waitrequest = 1;
    start_cmd(1, 16'd3, 24'd2);
    for (int i = 0; i < 100 && !avm_chipselect; i++) @(posedge clk) #1;
    @(posedge clk) #3;
    reset_n = 0;
    #1;
    chk("rst_mid_strobe", {avm_chipselect, avm_write_n}, 2'b01);
    chk("rst_mid_state", {busy, position, avm_writedata}, 49'h0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1;
    avm_waitrequest = 0;
    m_idx = 0;
    m_pos = 0;
    #1;
    chk("post_rst", {busy, position, cmd_ready}, {1'b0, 16'h0, 1'b1});
    start_cmd(1, 16'd1, 24'd1);
    finish_cmd(1, 1, 0);
    if (wr_data.size() == 1) chk("post_rst_data", wr_data[0], 32'h36);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
